// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder/subtractor.
// One operand bit is consumed per clock (LSB first) through a registered
// carry. Sub=0 computes A+B+Cin, Sub=1 computes A-B as A+~B+1, so Carry=1
// in subtract mode means "no borrow" (A >= B unsigned).
//
// Handshake: start is accepted only on a rising edge where ready=1 (IDLE).
// Operands, Cin and Sub are captured on that edge and are ignored afterwards.
// busy is high while bits are being processed (RUN). done pulses high for
// exactly one cycle (DONE) when Sum/Carry have just been updated. start seen
// while busy or done is dropped, never queued. ready/busy/done are decoded
// from the state register only, so they have no combinational input path.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  // The bit counter must be able to hold WIDTH, hence the extra bit.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sh_sum;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             s;
  logic             c_nx;
  logic [WIDTH-1:0] sum_nx;

  // Handshake and bit-slice combinational terms.
  always_comb begin
    accept   = (state == S_IDLE) && start;
    last_bit = (state == S_RUN) && (cnt == CNT_LAST);
    s        = a_sh[0] ^ b_sh[0] ^ c;
    c_nx     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    // New bit enters at the MSB; after WIDTH shifts the LSB of the result
    // has reached bit 0. Written as shifts so WIDTH=1 needs no special case.
    sum_nx   = (sh_sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last bit,
  // DONE always returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start)    state_nx = S_RUN;
      S_RUN:  if (last_bit) state_nx = S_DONE;
      S_DONE:               state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    ready = (state == S_IDLE);
    busy  = (state == S_RUN);
    done  = (state == S_DONE);
  end

  // Serial datapath: load on accept, one bit per RUN edge, publish result
  // on the final RUN edge. Sum/Carry hold at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sh_sum <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      Sum    <= '0;
      Carry  <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= Sub ? ~B : B;
      c      <= Sub ? 1'b1 : Cin;
      sh_sum <= '0;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c      <= c_nx;
      sh_sum <= sum_nx;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        Sum   <= sum_nx;
        Carry <= c_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: self-checking bench for serial_adder_seq.
// Two instances share one clock: an 8-bit unit for the main tests and a
// 1-bit unit for the registered full adder case. Expected results come from
// plain integer arithmetic on the operands.
module tb_serial_adder_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 8-bit DUT ----------------
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, carry8;
  logic [7:0] sum8;

  serial_adder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .Sub(sub8), .A(a8), .B(b8),
    .Cin(cin8), .ready(ready8), .busy(busy8), .done(done8), .Sum(sum8),
    .Carry(carry8)
  );

  // ---------------- 1-bit DUT ----------------
  logic start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic ready1, busy1, done1, carry1;
  logic [0:0] sum1;

  serial_adder_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .Sub(sub1), .A(a1), .B(b1),
    .Cin(cin1), .ready(ready1), .busy(busy1), .done(done1), .Sum(sum1),
    .Carry(carry1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last8 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {carry, sum} from whole-number arithmetic.
  function automatic logic [8:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] d;
    if (s) begin
      d = a - b;
      return {(a >= b), d};
    end
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  function automatic logic [1:0] model1(input logic s, input logic a, input logic b, input logic c);
    logic d;
    if (s) begin
      d = a ^ b;
      return {(a >= b), d};
    end
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble8();
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    cin8 = 1'($urandom);
    sub8 = 1'($urandom);
  endtask

  // Full operation on the 8-bit unit with cycle-exact flag checks.
  task automatic run_op8(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic c);
    logic [8:0] e;
    check("idle_ready", {busy8, ready8, done8}, 3'b010);
    sub8 = s; a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
    exp_q.push_back(model8(s, av, bv, c));
    step();                                   // E0
    start8 = 1'b0;
    scramble8();
    check("acc_flags", {busy8, ready8, done8}, 3'b100);
    for (int i = 1; i <= 8; i++) begin
      step();                                 // E1..E8
      if (i < 8) begin
        check("run_flags", {busy8, ready8, done8}, 3'b100);
        check("run_hold", {carry8, sum8}, last8);
      end
    end
    check("done_flags", {busy8, ready8, done8}, 3'b001);
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("result", {carry8, sum8}, e);
      last8 = e;
    end
    step();                                   // E9
    check("post_flags", {busy8, ready8, done8}, 3'b010);
    check("post_hold", {carry8, sum8}, last8);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [8:0] e;
    logic [1:0] e1;
    logic [7:0] ra, rb;
    logic rs, rc;

    step(); step();
    rst = 1'b0;
    check("rst_flags8", {busy8, ready8, done8}, 3'b010);
    check("rst_res8", {carry8, sum8}, 9'd0);
    check("rst_flags1", {busy1, ready1, done1}, 3'b010);
    check("rst_res1", {carry1, sum1}, 2'd0);

    // Directed cases.
    run_op8(1'b0, 8'h5A, 8'h3C, 1'b0);
    check("dir_5a3c", {carry8, sum8}, {1'b0, 8'h96});
    run_op8(1'b0, 8'hFF, 8'h01, 1'b0);
    check("dir_ff01", {carry8, sum8}, {1'b1, 8'h00});
    run_op8(1'b0, 8'hFF, 8'hFF, 1'b1);
    check("dir_ffff1", {carry8, sum8}, {1'b1, 8'hFF});
    run_op8(1'b1, 8'h10, 8'h01, 1'b1);
    check("dir_sub10", {carry8, sum8}, {1'b1, 8'h0F});
    run_op8(1'b1, 8'h00, 8'h01, 1'b0);
    check("dir_sub00", {carry8, sum8}, {1'b0, 8'hFF});

    // Random operations.
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      run_op8(rs, ra, rb, rc);
    end

    // start held high with changing operands during RUN and DONE.
    sub8 = 1'b0; a8 = 8'h21; b8 = 8'h42; cin8 = 1'b1; start8 = 1'b1;
    e = model8(1'b0, 8'h21, 8'h42, 1'b1);
    step();                                   // E0
    for (int i = 1; i <= 8; i++) begin
      scramble8();
      step();                                 // E1..E8
    end
    check("hold_done", {busy8, ready8, done8}, 3'b001);
    check("hold_res", {carry8, sum8}, e);
    last8 = e;
    sub8 = 1'b1; a8 = 8'h80; b8 = 8'h81; cin8 = 1'b0;
    step();                                   // E9: start in DONE dropped
    check("hold_e9", {busy8, ready8, done8}, 3'b010);
    e = model8(1'b1, 8'h80, 8'h81, 1'b0);
    step();                                   // E10: accepted from IDLE
    start8 = 1'b0;
    scramble8();
    check("hold_acc", {busy8, ready8, done8}, 3'b100);
    for (int i = 1; i <= 8; i++) step();
    check("hold2_done", {busy8, ready8, done8}, 3'b001);
    check("hold2_res", {carry8, sum8}, e);
    last8 = e;
    step();

    // Reset in the middle of a run.
    sub8 = 1'b0; a8 = 8'h77; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
    step();                                   // E0
    start8 = 1'b0;
    step(); step(); step();                   // E1..E3
    rst = 1'b1;
    step();                                   // E4
    rst = 1'b0;
    check("mrst_flags", {busy8, ready8, done8}, 3'b010);
    check("mrst_res", {carry8, sum8}, 9'd0);
    last8 = '0;
    exp_q.delete();
    run_op8(1'b0, 8'hC3, 8'h4E, 1'b1);        // accepted at E5

    // Width-1 unit: registered full adder.
    for (int k = 0; k < 16; k++) begin
      sub1 = k[3]; a1 = k[2]; b1 = k[1]; cin1 = k[0];
      e1 = model1(k[3], k[2], k[1], k[0]);
      start1 = 1'b1;
      step();                                 // E0
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      check("w1_acc", {busy1, ready1, done1}, 3'b100);
      step();                                 // E1
      check("w1_done", {busy1, ready1, done1}, 3'b001);
      check("w1_res", {carry1, sum1}, e1);
      step();                                 // E2
      check("w1_post", {busy1, ready1, done1}, 3'b010);
    end
    sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("w1_111", {done1, carry1, sum1}, 3'b111);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
